// File: rtl/vx_bank_req_sched_pkg.sv
// ---------------------------------------------------------------------------
// vx_bank_req_sched_pkg
//   Shared cache configuration for the bank request scheduler: the scheduler
//   FSM state encoding, the st1 source codes and the grant masks derived from
//   them.
// ---------------------------------------------------------------------------
package vx_bank_req_sched_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } sched_state_t;

    // Source codes carried on src_st1. Also the bit index of each source in
    // the request/grant vectors shared by the top and the arbiter.
    localparam logic [1:0] SRC_CORE = 2'd0;
    localparam logic [1:0] SRC_SNP  = 2'd1;
    localparam logic [1:0] SRC_MRVQ = 2'd2;
    localparam logic [1:0] SRC_FILL = 2'd3;  // fill and invalidation walk

    localparam int NUM_SRC = 4;

    // Sources that may still be served while the bank drains before a flush.
    localparam logic [NUM_SRC-1:0] DRAIN_MASK = (4'b0001 << SRC_FILL)
                                              | (4'b0001 << SRC_MRVQ);

    // INIT and FLUSH both run the line invalidation walk.
    function automatic logic is_walk_state(input sched_state_t s);
        return (s == ST_INIT) || (s == ST_FLUSH);
    endfunction

endpackage

// File: rtl/vx_bank_req_sched_arb.sv
// ---------------------------------------------------------------------------
// vx_bank_prio_arb
//   Fixed-priority arbiter for the bank request sources with a starvation
//   boost for the core port.
//   Order: fill > mrvq > snoop > core, except that a boosted core request
//   is placed ahead of snoop.
//
// Ports
//   clk, reset   : clock, asynchronous active-low reset
//   req          : raw source valids, indexed by SRC_* code
//   allow        : sources the scheduler state permits this cycle
//   stall        : bank pipe stall; suppresses every grant
//   grant        : one-hot (or zero) grant, indexed by SRC_* code
// ---------------------------------------------------------------------------
module vx_bank_prio_arb
    import vx_bank_req_sched_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] allow,
    input  logic               stall,
    output logic [NUM_SRC-1:0] grant
);

    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]      starve_cnt_reg;
    logic [CW-1:0]      starve_cnt_next;
    logic               boost;
    logic [NUM_SRC-1:0] req_eff;
    logic [1:0]         rank_src [NUM_SRC];  // source occupying each rank, 0 highest
    logic [NUM_SRC-1:0] rank_req;
    logic [NUM_SRC-1:0] rank_gnt;

    assign boost   = (starve_cnt_reg == LIMIT);
    assign req_eff = req & allow & {NUM_SRC{~stall}};

    always_comb begin
        rank_src[0] = SRC_FILL;
        rank_src[1] = SRC_MRVQ;
        rank_src[2] = boost ? SRC_CORE : SRC_SNP;
        rank_src[3] = boost ? SRC_SNP  : SRC_CORE;
    end

    // Ranked request vector and first-one select.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rank
        assign rank_req[gi] = req_eff[rank_src[gi]];
        if (gi == 0) begin : g_top
            assign rank_gnt[gi] = rank_req[gi];
        end else begin : g_lower
            assign rank_gnt[gi] = rank_req[gi] & ~(|rank_req[gi-1:0]);
        end
    end

    // Map the ranked grant back onto source indices.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rank_gnt[i]) begin
                grant[rank_src[i]] = 1'b1;
            end
        end
    end

    // Counts denied core cycles, including stalled ones; saturates at LIMIT.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!req[SRC_CORE] || grant[SRC_CORE]) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != LIMIT) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_reg <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
        end
    end

endmodule

// File: rtl/vx_bank_req_sched.sv
// ---------------------------------------------------------------------------
// vx_bank_req_sched
//   Cache bank request scheduler. Selects one of fill / mrvq / snoop / core
//   each cycle and registers it into the st1 stage. After reset, and on a
//   flush request (once the fill and mrvq queues have drained), it walks all
//   line indices issuing invalidation ops, then pulses flush_done.
//
// Ports
//   clk, reset                  : clock, asynchronous active-low reset
//   fill_*                      : DRAM fill source (valid/addr/data, ready)
//   mrvq_*                      : miss-reserve replay source (valid/addr, ready)
//   snp_*                       : snoop source (valid/addr/invalidate, ready)
//   core_*                      : core source (valid/addr/rw, ready)
//   flush_req / flush_done      : level flush request / completion pulse
//   stall_bank_pipe             : holds st1, walk counter and FSM state
//   *_st1                       : registered stage-1 request
//   src_st1                     : 0 core, 1 snoop, 2 mrvq, 3 fill/walk
// ---------------------------------------------------------------------------
module vx_bank_req_sched
    import vx_bank_req_sched_pkg::*;
#(
    parameter int LINE_ADDR_WIDTH  = 26,
    parameter int LINE_SELECT_BITS = 6,
    parameter int STARVE_LIMIT     = 8,
    parameter int BANK_LINE_WIDTH  = 128
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       fill_valid,
    input  logic [LINE_ADDR_WIDTH-1:0] fill_addr,
    input  logic [BANK_LINE_WIDTH-1:0] fill_data,
    output logic                       fill_ready,

    input  logic                       mrvq_valid,
    input  logic [LINE_ADDR_WIDTH-1:0] mrvq_addr,
    output logic                       mrvq_ready,

    input  logic                       snp_valid,
    input  logic [LINE_ADDR_WIDTH-1:0] snp_addr,
    input  logic                       snp_invalidate,
    output logic                       snp_ready,

    input  logic                       core_valid,
    input  logic [LINE_ADDR_WIDTH-1:0] core_addr,
    input  logic                       core_rw,
    output logic                       core_ready,

    input  logic                       flush_req,
    output logic                       flush_done,

    input  logic                       stall_bank_pipe,

    output logic                       valid_st1,
    output logic [LINE_ADDR_WIDTH-1:0] addr_st1,
    output logic [BANK_LINE_WIDTH-1:0] writedata_st1,
    output logic                       writefill_st1,
    output logic                       is_snp_st1,
    output logic                       snp_invalidate_st1,
    output logic                       mem_rw_st1,
    output logic                       inval_st1,
    output logic [1:0]                 src_st1
);

    localparam logic [LINE_SELECT_BITS-1:0] LAST_IDX = '1;

    sched_state_t                state_reg;
    sched_state_t                state_next;
    logic [LINE_SELECT_BITS-1:0] walk_cnt_reg;
    logic [LINE_SELECT_BITS-1:0] walk_cnt_next;
    logic                        flush_done_reg;
    logic                        flush_done_next;
    logic                        walk_op;

    logic [NUM_SRC-1:0]          req;
    logic [NUM_SRC-1:0]          allow;
    logic [NUM_SRC-1:0]          grant;

    logic                        valid_st1_reg,          valid_st1_next;
    logic [LINE_ADDR_WIDTH-1:0]  addr_st1_reg,           addr_st1_next;
    logic [BANK_LINE_WIDTH-1:0]  writedata_st1_reg,      writedata_st1_next;
    logic                        writefill_st1_reg,      writefill_st1_next;
    logic                        is_snp_st1_reg,         is_snp_st1_next;
    logic                        snp_invalidate_st1_reg, snp_invalidate_st1_next;
    logic                        mem_rw_st1_reg,         mem_rw_st1_next;
    logic                        inval_st1_reg,          inval_st1_next;
    logic [1:0]                  src_st1_reg,            src_st1_next;

    // ---------------- arbitration ----------------
    always_comb begin
        req           = '0;
        req[SRC_FILL] = fill_valid;
        req[SRC_MRVQ] = mrvq_valid;
        req[SRC_SNP]  = snp_valid;
        req[SRC_CORE] = core_valid;
    end

    vx_bank_prio_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .allow (allow),
        .stall (stall_bank_pipe),
        .grant (grant)
    );

    assign fill_ready = grant[SRC_FILL];
    assign mrvq_ready = grant[SRC_MRVQ];
    assign snp_ready  = grant[SRC_SNP];
    assign core_ready = grant[SRC_CORE];

    // ---------------- FSM next state ----------------
    always_comb begin
        state_next      = state_reg;
        walk_cnt_next   = walk_cnt_reg;
        flush_done_next = 1'b0;
        allow           = '0;
        walk_op         = 1'b0;

        if (is_walk_state(state_reg)) begin
            // flush_req is deliberately not looked at while walking.
            if (!stall_bank_pipe) begin
                walk_op       = 1'b1;
                walk_cnt_next = walk_cnt_reg + 1'b1;
                if (walk_cnt_reg == LAST_IDX) begin
                    state_next      = ST_RUN;
                    flush_done_next = 1'b1;
                end
            end
        end else begin
            case (state_reg)
                ST_RUN: begin
                    // The flush cycle itself already stops new snoop/core work
                    // while still letting fill and mrvq through.
                    allow = flush_req ? DRAIN_MASK : '1;
                    if (!stall_bank_pipe && flush_req) begin
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    allow = DRAIN_MASK;
                    if (!stall_bank_pipe && !fill_valid && !mrvq_valid) begin
                        state_next    = ST_FLUSH;
                        walk_cnt_next = '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- st1 next contents ----------------
    always_comb begin
        valid_st1_next          = 1'b0;
        addr_st1_next           = '0;
        writedata_st1_next      = '0;
        writefill_st1_next      = 1'b0;
        is_snp_st1_next         = 1'b0;
        snp_invalidate_st1_next = 1'b0;
        mem_rw_st1_next         = 1'b0;
        inval_st1_next          = 1'b0;
        src_st1_next            = SRC_CORE;

        if (walk_op) begin
            valid_st1_next = 1'b1;
            inval_st1_next = 1'b1;
            addr_st1_next  = LINE_ADDR_WIDTH'(walk_cnt_reg);
            src_st1_next   = SRC_FILL;
        end else if (grant[SRC_FILL]) begin
            valid_st1_next     = 1'b1;
            addr_st1_next      = fill_addr;
            writedata_st1_next = fill_data;
            writefill_st1_next = 1'b1;
            src_st1_next       = SRC_FILL;
        end else if (grant[SRC_MRVQ]) begin
            valid_st1_next = 1'b1;
            addr_st1_next  = mrvq_addr;
            src_st1_next   = SRC_MRVQ;
        end else if (grant[SRC_SNP]) begin
            valid_st1_next          = 1'b1;
            addr_st1_next           = snp_addr;
            is_snp_st1_next         = 1'b1;
            snp_invalidate_st1_next = snp_invalidate;
            src_st1_next            = SRC_SNP;
        end else if (grant[SRC_CORE]) begin
            valid_st1_next  = 1'b1;
            addr_st1_next   = core_addr;
            mem_rw_st1_next = core_rw;
            src_st1_next    = SRC_CORE;
        end
    end

    // ---------------- state and st1 registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg              <= ST_INIT;
            walk_cnt_reg           <= '0;
            flush_done_reg         <= 1'b0;
            valid_st1_reg          <= 1'b0;
            addr_st1_reg           <= '0;
            writedata_st1_reg      <= '0;
            writefill_st1_reg      <= 1'b0;
            is_snp_st1_reg         <= 1'b0;
            snp_invalidate_st1_reg <= 1'b0;
            mem_rw_st1_reg         <= 1'b0;
            inval_st1_reg          <= 1'b0;
            src_st1_reg            <= SRC_CORE;
        end else begin
            // State and counter next values already hold during a stall;
            // flush_done_next is only ever high for a non-stalled wrap.
            state_reg      <= state_next;
            walk_cnt_reg   <= walk_cnt_next;
            flush_done_reg <= flush_done_next;
            if (!stall_bank_pipe) begin
                valid_st1_reg          <= valid_st1_next;
                addr_st1_reg           <= addr_st1_next;
                writedata_st1_reg      <= writedata_st1_next;
                writefill_st1_reg      <= writefill_st1_next;
                is_snp_st1_reg         <= is_snp_st1_next;
                snp_invalidate_st1_reg <= snp_invalidate_st1_next;
                mem_rw_st1_reg         <= mem_rw_st1_next;
                inval_st1_reg          <= inval_st1_next;
                src_st1_reg            <= src_st1_next;
            end
        end
    end

    assign flush_done         = flush_done_reg;
    assign valid_st1          = valid_st1_reg;
    assign addr_st1           = addr_st1_reg;
    assign writedata_st1      = writedata_st1_reg;
    assign writefill_st1      = writefill_st1_reg;
    assign is_snp_st1         = is_snp_st1_reg;
    assign snp_invalidate_st1 = snp_invalidate_st1_reg;
    assign mem_rw_st1         = mem_rw_st1_reg;
    assign inval_st1          = inval_st1_reg;
    assign src_st1            = src_st1_reg;

endmodule

// File: tb/tb_vx_bank_req_sched.sv
module tb_vx_bank_req_sched;

    localparam int AW = 26;
    localparam int DW = 64;

    logic          clk;
    logic          reset;
    logic          fill_valid;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    logic          fill_ready;
    logic          mrvq_valid;
    logic [AW-1:0] mrvq_addr;
    logic          mrvq_ready;
    logic          snp_valid;
    logic [AW-1:0] snp_addr;
    logic          snp_invalidate;
    logic          snp_ready;
    logic          core_valid;
    logic [AW-1:0] core_addr;
    logic          core_rw;
    logic          core_ready;
    logic          flush_req;
    logic          flush_done;
    logic          stall_bank_pipe;
    logic          valid_st1;
    logic [AW-1:0] addr_st1;
    logic [DW-1:0] writedata_st1;
    logic          writefill_st1;
    logic          is_snp_st1;
    logic          snp_invalidate_st1;
    logic          mem_rw_st1;
    logic          inval_st1;
    logic [1:0]    src_st1;

    int checks;
    int failures;

    vx_bank_req_sched #(
        .LINE_ADDR_WIDTH  (AW),
        .LINE_SELECT_BITS (6),
        .STARVE_LIMIT     (8),
        .BANK_LINE_WIDTH  (DW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .fill_valid         (fill_valid),
        .fill_addr          (fill_addr),
        .fill_data          (fill_data),
        .fill_ready         (fill_ready),
        .mrvq_valid         (mrvq_valid),
        .mrvq_addr          (mrvq_addr),
        .mrvq_ready         (mrvq_ready),
        .snp_valid          (snp_valid),
        .snp_addr           (snp_addr),
        .snp_invalidate     (snp_invalidate),
        .snp_ready          (snp_ready),
        .core_valid         (core_valid),
        .core_addr          (core_addr),
        .core_rw            (core_rw),
        .core_ready         (core_ready),
        .flush_req          (flush_req),
        .flush_done         (flush_done),
        .stall_bank_pipe    (stall_bank_pipe),
        .valid_st1          (valid_st1),
        .addr_st1           (addr_st1),
        .writedata_st1      (writedata_st1),
        .writefill_st1      (writefill_st1),
        .is_snp_st1         (is_snp_st1),
        .snp_invalidate_st1 (snp_invalidate_st1),
        .mem_rw_st1         (mem_rw_st1),
        .inval_st1          (inval_st1),
        .src_st1            (src_st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Readies packed as {fill, mrvq, snp, core}.
    function automatic logic [3:0] rdy();
        return {fill_ready, mrvq_ready, snp_ready, core_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect walk ops for indices first..last on consecutive edges.
    task automatic walk(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            tick();
            chk({tag, "_valid"}, 64'(valid_st1), 64'd1);
            chk({tag, "_inval"}, 64'(inval_st1), 64'd1);
            chk({tag, "_addr"},  64'(addr_st1),  64'(i));
            chk({tag, "_src"},   64'(src_st1),   64'd3);
            chk({tag, "_done"},  64'(flush_done), (i == 63) ? 64'd1 : 64'd0);
            if (i != 63) chk({tag, "_rdy"}, 64'(rdy()), 64'd0);
        end
        $display("walk %s indices %0d..%0d checked", tag, first, last);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; stall_bank_pipe = 1'b0; flush_req = 1'b0;
        fill_valid = 1'b1; fill_addr = '0; fill_data = '0;
        mrvq_valid = 1'b0; mrvq_addr = '0;
        snp_valid = 1'b0; snp_addr = '0; snp_invalidate = 1'b0;
        core_valid = 1'b0; core_addr = '0; core_rw = 1'b0;
        #1 reset = 1'b0;
        #1;
        // Reset state
        chk("rst_valid", 64'(valid_st1), 64'd0);
        chk("rst_addr",  64'(addr_st1), 64'd0);
        chk("rst_inval", 64'(inval_st1), 64'd0);
        chk("rst_done",  64'(flush_done), 64'd0);
        chk("rst_rdy",   64'(rdy()), 64'd0);
        $display("reset state checked");
        tick();
        chk("rst_rdy_edge", 64'(rdy()), 64'd0);
        fill_valid = 1'b0;
        reset = 1'b1;

        // Initial walk 0..63, then RUN with nothing pending
        walk(0, 63, "init");
        tick();
        chk("run_idle_valid", 64'(valid_st1), 64'd0);
        chk("run_idle_done",  64'(flush_done), 64'd0);

        // All four valid: fill, mrvq, snoop, core in turn
        fill_valid = 1; fill_addr = 26'h123456; fill_data = 64'hDEADBEEF_CAFEF00D;
        mrvq_valid = 1; mrvq_addr = 26'h0000AA;
        snp_valid = 1; snp_addr = 26'h0000BB; snp_invalidate = 1;
        core_valid = 1; core_addr = 26'h0000CC; core_rw = 1;
        #1 chk("all_rdy_fill", 64'(rdy()), 64'b1000);
        tick();
        chk("fill_src",  64'(src_st1), 64'd3);
        chk("fill_addr", 64'(addr_st1), 64'h123456);
        chk("fill_data", writedata_st1, 64'hDEADBEEF_CAFEF00D);
        chk("fill_wf",   64'(writefill_st1), 64'd1);
        chk("fill_rw",   64'(mem_rw_st1), 64'd0);
        chk("fill_inv",  64'(inval_st1), 64'd0);
        $display("txn fill src=%0d addr=%0h", src_st1, addr_st1);
        fill_valid = 0;
        #1 chk("all_rdy_mrvq", 64'(rdy()), 64'b0100);
        tick();
        chk("mrvq_src",  64'(src_st1), 64'd2);
        chk("mrvq_addr", 64'(addr_st1), 64'hAA);
        chk("mrvq_data", writedata_st1, 64'd0);
        chk("mrvq_wf",   64'(writefill_st1), 64'd0);
        $display("txn mrvq src=%0d addr=%0h", src_st1, addr_st1);
        mrvq_valid = 0;
        #1 chk("all_rdy_snp", 64'(rdy()), 64'b0010);
        tick();
        chk("snp_src",  64'(src_st1), 64'd1);
        chk("snp_addr", 64'(addr_st1), 64'hBB);
        chk("snp_is",   64'(is_snp_st1), 64'd1);
        chk("snp_inv",  64'(snp_invalidate_st1), 64'd1);
        chk("snp_rw",   64'(mem_rw_st1), 64'd0);
        $display("txn snp src=%0d addr=%0h", src_st1, addr_st1);
        snp_valid = 0;
        #1 chk("all_rdy_core", 64'(rdy()), 64'b0001);
        tick();
        chk("core_src",  64'(src_st1), 64'd0);
        chk("core_addr", 64'(addr_st1), 64'hCC);
        chk("core_rw",   64'(mem_rw_st1), 64'd1);
        chk("core_is",   64'(is_snp_st1), 64'd0);
        $display("txn core src=%0d addr=%0h", src_st1, addr_st1);
        core_valid = 0;
        tick();
        chk("idle_valid", 64'(valid_st1), 64'd0);

        // Starvation: snoop wins 8 times, core on cycle 9, snoop again on 10
        snp_valid = 1; snp_invalidate = 0; core_valid = 1; core_rw = 0;
        for (int c = 1; c <= 10; c++) begin
            #1 chk($sformatf("starve_rdy_c%0d", c), 64'(rdy()), (c == 9) ? 64'b0001 : 64'b0010);
            tick();
            chk($sformatf("starve_src_c%0d", c), 64'(src_st1), (c == 9) ? 64'd0 : 64'd1);
            $display("txn starve cycle %0d src=%0d", c, src_st1);
        end
        snp_valid = 0; core_valid = 0;

        // Stall holds st1; starvation keeps counting while stalled
        fill_valid = 1; fill_addr = 26'h0ABCDE; fill_data = 64'h1;
        #1 chk("pre_stall_rdy", 64'(rdy()), 64'b1000);
        tick();
        fill_valid = 0; stall_bank_pipe = 1; snp_valid = 1; core_valid = 1;
        #1 chk("stall_rdy0", 64'(rdy()), 64'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("stall_addr_%0d", k), 64'(addr_st1), 64'h0ABCDE);
            chk($sformatf("stall_wf_%0d", k),   64'(writefill_st1), 64'd1);
            chk($sformatf("stall_rdy_%0d", k),  64'(rdy()), 64'd0);
        end
        stall_bank_pipe = 0;
        #1 chk("post_stall_boost", 64'(rdy()), 64'b0001);
        tick();
        chk("post_stall_src", 64'(src_st1), 64'd0);
        $display("txn stalled-boost core src=%0d", src_st1);

        // Flush with mrvq pending: only mrvq served, then walk
        mrvq_valid = 1; mrvq_addr = 26'h111; flush_req = 1;
        #1 chk("flush_rdy_run", 64'(rdy()), 64'b0100);
        tick();
        chk("drain_src0", 64'(src_st1), 64'd2);
        chk("drain_addr0", 64'(addr_st1), 64'h111);
        #1 chk("drain_rdy", 64'(rdy()), 64'b0100);
        tick();
        chk("drain_src1", 64'(src_st1), 64'd2);
        mrvq_valid = 0;
        #1 chk("drain_idle_rdy", 64'(rdy()), 64'd0);
        tick();
        chk("drain_end_valid", 64'(valid_st1), 64'd0);
        chk("drain_end_done",  64'(flush_done), 64'd0);
        walk(0, 31, "flush_a");
        flush_req = 0;
        walk(32, 63, "flush_b");
        chk("flush_end_boost", 64'(rdy()), 64'b0001);
        tick();
        chk("flush_end_src", 64'(src_st1), 64'd0);
        chk("flush_end_done", 64'(flush_done), 64'd0);
        snp_valid = 0; core_valid = 0;

        // Reset mid-RUN, stall mid-INIT at 20, reset at 40
        fill_valid = 1; fill_addr = 26'h2;
        reset = 0;
        #1 chk("rst2_valid", 64'(valid_st1), 64'd0);
        chk("rst2_rdy", 64'(rdy()), 64'd0);
        tick();
        reset = 1;
        walk(0, 20, "init2");
        stall_bank_pipe = 1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("istall_addr_%0d", k), 64'(addr_st1), 64'd20);
            chk($sformatf("istall_rdy_%0d", k),  64'(rdy()), 64'd0);
        end
        stall_bank_pipe = 0;
        walk(21, 40, "init2b");
        reset = 0;
        #1 chk("rst3_valid", 64'(valid_st1), 64'd0);
        chk("rst3_addr",  64'(addr_st1), 64'd0);
        chk("rst3_inval", 64'(inval_st1), 64'd0);
        chk("rst3_rdy",   64'(rdy()), 64'd0);
        tick();
        reset = 1;
        walk(0, 63, "init3");
        chk("init3_run_fill_rdy", 64'(rdy()), 64'b1000);
        tick();
        chk("init3_fill_src", 64'(src_st1), 64'd3);
        chk("init3_fill_wf",  64'(writefill_st1), 64'd1);
        fill_valid = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vx_bank_req_sched.md
VX_BANK_REQ_SCHED -- requirements
Module: VX_bank_req_sched

Interface
REQ-001 SHALL have parameter LINE_ADDR_WIDTH, default 26, width of the line address.
REQ-002 SHALL have parameter LINE_SELECT_BITS, default 6, number of line-index bits; the line count is 2^LINE_SELECT_BITS.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, the number of consecutive denied cycles before a core request is boosted.
REQ-004 SHALL have ports clk in 1, the single clock; reset in 1, asynchronous active-low.
REQ-005 SHALL have ports fill_valid in 1, fill_addr in LINE_ADDR_WIDTH, fill_data in BANK_LINE_WIDTH, fill_ready out 1: DRAM fill source.
REQ-006 SHALL have ports mrvq_valid in 1, mrvq_addr in LINE_ADDR_WIDTH, mrvq_ready out 1: miss-reserve replay source.
REQ-007 SHALL have ports snp_valid in 1, snp_addr in LINE_ADDR_WIDTH, snp_invalidate in 1, snp_ready out 1: snoop source.
REQ-008 SHALL have ports core_valid in 1, core_addr in LINE_ADDR_WIDTH, core_rw in 1, core_ready out 1: core request source.
REQ-009 SHALL have ports flush_req in 1 (level, request full invalidation walk) and flush_done out 1 (one-cycle pulse when the walk completes).
REQ-010 SHALL have port stall_bank_pipe in 1; while high, the st1 register holds its contents.
REQ-011 SHALL have outputs valid_st1 1, addr_st1 LINE_ADDR_WIDTH, writedata_st1 BANK_LINE_WIDTH, writefill_st1 1, is_snp_st1 1, snp_invalidate_st1 1, mem_rw_st1 1, inval_st1 1 (walk op), src_st1 2 (0 core, 1 snoop, 2 mrvq, 3 fill/walk).

Function
REQ-012 SHALL implement FSM states INIT, RUN, DRAIN, FLUSH; reset enters INIT.
REQ-013 INIT/FLUSH SHALL issue one inval_st1 op per non-stalled cycle, with addr_st1[LINE_SELECT_BITS-1:0] equal to a counter running 0..2^LINE_SELECT_BITS-1 and upper address bits zero.
REQ-014 When the counter wraps from its last index on an accepted op, INIT/FLUSH SHALL go to RUN and pulse flush_done for exactly one cycle; the pulse SHALL also occur at the end of INIT.
REQ-015 In RUN, flush_req high SHALL move the FSM to DRAIN; DRAIN SHALL grant only fill and mrvq, and SHALL go to FLUSH when both are idle.
REQ-016 In RUN, fixed priority SHALL be fill > mrvq > snoop > core, except that a boosted core outranks snoop.
REQ-017 A starvation counter SHALL increment each cycle core_valid is high and core is not granted, SHALL clear on a core grant or when core_valid is low, SHALL saturate, and SHALL boost core when the count reaches STARVE_LIMIT.
REQ-018 Exactly one x_ready SHALL be high per cycle, and only when the state permits and stall_bank_pipe is low.
REQ-019 Each x_ready SHALL be combinational from the valids, FSM state, starvation counter and stall_bank_pipe.
REQ-020 A transfer SHALL occur when x_valid and x_ready are both high; its fields SHALL appear on the st1 outputs on the next clock edge (latency 1).
REQ-021 A non-stalled cycle with no transfer and no walk op SHALL load valid_st1 = 0.
REQ-022 While stall_bank_pipe is high, all st1 outputs, the walk counter and the FSM state SHALL hold.
REQ-023 The starvation counter SHALL still increment while stalled.
REQ-024 Field mapping: writefill_st1 = 1 for fill only; is_snp_st1 and snp_invalidate_st1 from the snoop source; mem_rw_st1 from core_rw for core only and 0 for all other sources.
REQ-025 writedata_st1 SHALL carry fill_data for a fill and SHALL be 0 for all other sources.
REQ-026 Simultaneous flush_req and a fill in RUN: the fill SHALL be granted the same cycle, and the state SHALL become DRAIN.
REQ-027 flush_req asserted during INIT or FLUSH SHALL be ignored.

Reset
REQ-028 On reset low, all st1 outputs, flush_done, the walk counter and the starvation counter SHALL be 0, and the state SHALL be INIT.
REQ-029 All x_ready outputs SHALL be 0 while reset is low.
REQ-030 Reset asserted mid-walk or mid-drain SHALL abort the operation and restart INIT from index 0.

Structure
REQ-031 The state encoding and the src_st1 code constants SHALL live in the shared cache config package.
REQ-032 The arbiter SHALL be a sub-module VX_bank_prio_arb (priority select plus starvation boost); the FSM and the st1 register stay in the top module.

Verification
REQ-033 Reset release, stall low: 64 inval_st1 ops with addresses 0..63 in consecutive cycles, then flush_done, then RUN.
REQ-034 All four sources valid in RUN: grant order fill, mrvq, snoop, core as each deasserts after its transfer; src_st1 = 3, 2, 1, 0.
REQ-035 snp_valid and core_valid held high: core granted exactly when the counter reaches 8 (cycle 9); counter then 0.
REQ-036 stall_bank_pipe high for 5 cycles mid-INIT at index 20: addr_st1 holds 20, all ready low; resume at 21.
REQ-037 flush_req with mrvq_valid pending: snoop and core blocked, mrvq drains, then 64-op walk, then flush_done pulse.
REQ-038 Reset low at walk index 40: outputs 0 immediately; after release the walk restarts at 0.
